// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving one external full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             c_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf_o,
`endif
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_c_o,
  input  logic             fa_f_i,
  input  logic             fa_c_i
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic run;
  assign run = (state_q == S_RUN);

  // Adder-side bits come straight from flops so the external cell never sees a comb loop.
  assign fa_a_o = run & a_q[0];
  assign fa_b_o = run & b_q[0];
  assign fa_c_o = run & carry_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          carry_d = c_in_i;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = {fa_f_i, sum_q[WIDTH-1:1]};
        carry_d = fa_c_i;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_c_i;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this last bit
          ovf_d   = carry_q ^ fa_c_i;
`endif
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_FIN);
    done_d = (state_q == S_FIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign c_out_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2, full adder modelled behaviourally.
module tb_serial_adder_ctrl;
  localparam int W  = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, cin;
  logic [W-1:0] opa, opb, sum;
  logic         busy, done, cout, ovf;
  logic         fa_a, fa_b, fa_c, fa_f, fa_co;

  logic          start2, cin2;
  logic [W2-1:0] opa2, opb2, sum2;
  logic          busy2, done2, cout2, ovf2;
  logic          fa_a2, fa_b2, fa_c2, fa_f2, fa_co2;

  assign {fa_co,  fa_f}  = {1'b0, fa_a}  + {1'b0, fa_b}  + {1'b0, fa_c};
  assign {fa_co2, fa_f2} = {1'b0, fa_a2} + {1'b0, fa_b2} + {1'b0, fa_c2};

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_a_i(opa), .op_b_i(opb), .c_in_i(cin),
    .busy_o(busy), .done_o(done), .sum_o(sum), .c_out_o(cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_o(ovf),
`endif
    .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_c_o(fa_c), .fa_f_i(fa_f), .fa_c_i(fa_co)
  );

  serial_adder_ctrl #(.WIDTH(W2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .op_a_i(opa2), .op_b_i(opb2), .c_in_i(cin2),
    .busy_o(busy2), .done_o(done2), .sum_o(sum2), .c_out_o(cout2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_o(ovf2),
`endif
    .fa_a_o(fa_a2), .fa_b_o(fa_b2), .fa_c_o(fa_c2), .fa_f_i(fa_f2), .fa_c_i(fa_co2)
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  typedef struct packed { logic ovf; logic cout; logic [W-1:0] sum; } exp_t;
  exp_t         sb[$];
  logic [2:0]   sb2[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    exp_t e;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0; cin = 1'b0;
    start2 = 1'b0; opa2 = '0; opb2 = '0; cin2 = 1'b0;
    tick; tick;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, cout, sum} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, cout, sum}); end
    n_checks++;
    if ({fa_a, fa_b, fa_c} !== 3'b000)
      begin n_fail++; $display("FAIL reset_fa: got %b expected 000", {fa_a, fa_b, fa_c}); end
    n_checks++;
    if ({busy2, done2, cout2, sum2} !== '0)
      begin n_fail++; $display("FAIL reset_w2: got %h expected 0", {busy2, done2, cout2, sum2}); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
  endtask

  // START seen in cycle 0; BUSY in cycles 1..9, DONE in cycle 10.
  task automatic test_basic;
    exp_t e;
    opa = 8'h35; opb = 8'h4A; cin = 1'b0; start = 1'b1;
    sb.push_back(model(opa, opb, cin));
    tick; start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      n_checks++;
      if (busy !== (k <= 9)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b expected %b", k, busy, (k <= 9)); end
      n_checks++;
      if (done !== (k == 10)) begin n_fail++; $display("FAIL basic_done c%0d: got %b expected %b", k, done, (k == 10)); end
      if (k == 1) begin
        n_checks++;
        if ({fa_a, fa_b, fa_c} !== 3'b100) begin n_fail++; $display("FAIL basic_fa_first: got %b expected 100", {fa_a, fa_b, fa_c}); end
      end
      if (k == 9) begin
        n_checks++;
        if ({fa_a, fa_b, fa_c} !== 3'b000) begin n_fail++; $display("FAIL basic_fa_fin: got %b expected 000", {fa_a, fa_b, fa_c}); end
      end
      if (done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({cout, sum} !== {e.cout, e.sum}) begin n_fail++; $display("FAIL basic_sum: got %h expected %h", {cout, sum}, {e.cout, e.sum}); end
      end
      tick;
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic         tc [5];
    exp_t e;
    bit   got;
    ta = '{8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h80};
    tb = '{8'h01, 8'h01, 8'h00, 8'hFF, 8'h80};
    tc = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 5; i++) begin
      opa = ta[i]; opb = tb[i]; cin = tc[i]; start = 1'b1;
      sb.push_back(model(opa, opb, cin));
      tick; start = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (done === 1'b1) begin got = 1'b1; break; end
        tick;
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL vec%0d_timeout: got no done expected done", i); void'(sb.pop_front()); end
      else begin
        e = sb.pop_front();
        if ({cout, sum} !== {e.cout, e.sum}) begin n_fail++; $display("FAIL vec%0d_sum: got %h expected %h", i, {cout, sum}, {e.cout, e.sum}); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== e.ovf) begin n_fail++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf, e.ovf); end
`endif
      end
      tick;
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   base;
    base = done_cnt;
    opa = 8'h12; opb = 8'hC3; cin = 1'b1; start = 1'b1;
    sb.push_back(model(opa, opb, cin));
    tick;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 3 || k == 6);
      if (start) begin opa = W'($urandom); opb = W'($urandom); cin = 1'b1; end
      if (k == 10) begin
        n_checks++;
        if (done !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL ignore_done: got %b expected 1", done); end
        else begin
          e = sb.pop_front();
          n_checks++;
          if ({cout, sum} !== {e.cout, e.sum}) begin n_fail++; $display("FAIL ignore_sum: got %h expected %h", {cout, sum}, {e.cout, e.sum}); end
        end
      end
      if (k == 12) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_queued: got busy %b expected 0", busy); end
      end
      tick;
    end
    start = 1'b0;
    n_checks++;
    if (done_cnt - base !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", done_cnt - base); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   base;
    bit   got;
    opa = 8'hFF; opb = 8'h00; cin = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    for (int k = 1; k < 5; k++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, cout, sum} !== '0) begin n_fail++; $display("FAIL abort_outputs: got %h expected 0", {busy, done, cout, sum}); end
    n_checks++;
    if ({fa_a, fa_b, fa_c} !== 3'b000) begin n_fail++; $display("FAIL abort_fa: got %b expected 000", {fa_a, fa_b, fa_c}); end
    base = done_cnt;
    for (int k = 0; k < 12; k++) tick;
    n_checks++;
    if (done_cnt != base || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - base); end
    opa = 8'h12; opb = 8'h34; cin = 1'b1; start = 1'b1;
    sb.push_back(model(opa, opb, cin));
    tick; start = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      tick;
    end
    e = sb.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL abort_restart: got no done expected done"); end
    else if ({cout, sum} !== {e.cout, e.sum}) begin n_fail++; $display("FAIL abort_restart: got %h expected %h", {cout, sum}, {e.cout, e.sum}); end
    tick;
  endtask

  // START held 30 cycles: accepts at edges 0, 10, 20, so DONE in cycles 10, 20, 30.
  task automatic test_back_to_back;
    exp_t e;
    int   ndone;
    opa = 8'hA5; opb = 8'h5A; cin = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(opa, opb, cin));
    ndone = 0;
    tick;
    for (int k = 1; k <= 40; k++) begin
      if (k == 30) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        n_checks++;
        if (k != 10 * ndone) begin n_fail++; $display("FAIL b2b_period: got cycle %0d expected %0d", k, 10 * ndone); end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if ({cout, sum} !== {e.cout, e.sum}) begin n_fail++; $display("FAIL b2b_sum: got %h expected %h", {cout, sum}, {e.cout, e.sum}); end
        end
      end
      tick;
    end
    n_checks++;
    if (ndone != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", ndone); sb.delete(); end
  endtask

  task automatic test_random;
    exp_t e;
    bit   got;
    for (int i = 0; i < 1000; i++) begin
      opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom); start = 1'b1;
      sb.push_back(model(opa, opb, cin));
      tick; start = 1'b0;
      opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom);
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (done === 1'b1) begin got = 1'b1; break; end
        tick;
      end
      e = sb.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL rand8_timeout #%0d: got no done expected done", i); end
      else if ({ovf & e.ovf, cout, sum} !== {e.ovf & ovf, e.cout, e.sum}) begin
        n_fail++; $display("FAIL rand8 #%0d: got %h expected %h", i, {cout, sum}, {e.cout, e.sum});
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_checks++;
      if (ovf !== e.ovf) begin n_fail++; $display("FAIL rand8_ovf #%0d: got %b expected %b", i, ovf, e.ovf); end
`endif
      tick;
    end
  endtask

  task automatic test_random_w2;
    logic [2:0] e;
    bit         got;
    for (int i = 0; i < 1000; i++) begin
      opa2 = W2'($urandom); opb2 = W2'($urandom); cin2 = 1'($urandom); start2 = 1'b1;
      sb2.push_back({1'b0, opa2} + {1'b0, opb2} + {2'b00, cin2});
      tick; start2 = 1'b0;
      opa2 = W2'($urandom); opb2 = W2'($urandom);
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (done2 === 1'b1) begin got = 1'b1; break; end
        tick;
      end
      e = sb2.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL rand2_timeout #%0d: got no done expected done", i); end
      else if ({cout2, sum2} !== e) begin n_fail++; $display("FAIL rand2 #%0d: got %h expected %h", i, {cout2, sum2}, e); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_random_w2;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
